scp_mc_core: RTL and testbench
==============================

Name: scp_mc_core

Overview:
- Parametrised multi-cycle successor to the 8-bit single-cycle accumulator processor (SCP).
- Generalises data width and address width, and replaces the 3-bit opcode with a 4-bit ISA that adds flags, shifts in both directions, conditional branches, HALT, and a start/done handshake.
- Instruction and data memories sit outside the core on synchronous one-cycle-latency buses; the core holds PC, IR, ACC, the C flag and the IO output register.

Parameters:
DW, 8, data/accumulator width (>=4)
AW, 5, instruction and data memory address width; PC width; IW = 4+AW

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin execution at PC=0; sampled only in IDLE or HALTED
done  out  1  high while in HALTED
im_addr  out  AW  instruction address (=PC)
im_rd  out  1  instruction read strobe
im_data  in  IW  instruction, valid the cycle after im_rd; {opcode[3:0], operand[AW-1:0]}
dm_addr  out  AW  data address (=IR operand)
dm_rd  out  1  data read strobe
dm_wr  out  1  data write strobe
dm_wdata  out  DW  write data (=ACC)
dm_rdata  in  DW  read data, valid the cycle after dm_rd
io_in  in  DW  input port
io_out  out  DW  registered output port
io_valid  out  1  one-cycle pulse when io_out updates

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE; PC, IR, ACC, C, io_out = 0.
  - All strobes, io_valid and done = 0, immediately, including mid-instruction; a pending dm_wr is dropped.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, HALTED.
  - IDLE: start=1 -> PC<=0, FETCH.
  - FETCH: im_rd=1, im_addr=PC -> DECODE.
  - DECODE: IR<=im_data; PC<=PC+1 mod 2^AW (2^AW-1 wraps to 0) -> EXEC.
  - EXEC: performs the opcode action. LDA/ADD/SUB assert dm_rd with dm_addr=operand -> MEM. All other opcodes -> FETCH, except HALT -> HALTED.
  - MEM: consumes dm_rdata, updates ACC/C -> FETCH.
  - HALTED: done=1. start=1 -> PC<=0, C<=0, FETCH (ACC and io_out retained).
- Strobes, addresses and dm_wdata are combinational decodes of state/IR/ACC/PC; io_out, io_valid and done are registered/state-derived. No combinational path from any input to any output.
- Opcodes (Z = ACC==0, combinational):
  - 0 NOP.
  - 1 LDA: ACC<=M.
  - 2 STA: dm_wr=1, dm_wdata=ACC in EXEC.
  - 3 ADD: {C,ACC}<=ACC+M (DW+1-bit sum).
  - 4 SUB: ACC<=ACC-M mod 2^DW; C<=1 iff ACC<M unsigned (borrow).
  - 5 SHL: C<=ACC[DW-1], ACC<=ACC<<1, zero fill.
  - 6 SHR: C<=ACC[0], ACC<=ACC>>1, zero fill.
  - 7 IN: ACC<=io_in, sampled in EXEC.
  - 8 OUT: io_out<=ACC, io_valid=1 for the following cycle only.
  - 9 JMP: PC<=operand.
  - A JZ: PC<=operand if Z.
  - B JC: PC<=operand if C.
  - C HALT.
  - D-F: treated as NOP.
- Flags: C changes only on ADD, SUB, SHL, SHR, and clears on restart. LDA and IN leave C unchanged.
- Branch writes in EXEC override the DECODE increment.
- Latency:
  - 3 cycles (FETCH/DECODE/EXEC) for NOP, STA, SHL, SHR, IN, OUT, jumps, HALT.
  - 4 cycles for LDA, ADD, SUB.
- start is ignored in FETCH, DECODE, EXEC and MEM. start held high in HALTED restarts immediately; done drops on the next edge.

Test Plan:
(DW=8, AW=5 throughout.)
1. Reset: assert reset=0 during the MEM cycle of an ADD -> dm_rd, dm_wr, io_valid, done drop asynchronously, ACC=0; after release with start=0 the core stays in IDLE with no strobes for 20 cycles.
2. Arithmetic program at addr 0-3: IN, ADD 3, OUT, HALT; io_in=0x25, M[3]=0xE0 -> ACC=0x05, C=1; io_out=0x05 with exactly one io_valid pulse; done rises 13 clock edges after the edge sampling start.
3. Borrow and branches: ACC=0x03, SUB with M=0x05 -> ACC=0xFE, C=1; JZ 0x0A not taken (next im_addr = PC+1); JC 0x10 taken (next im_addr=0x10).
4. Wrap: JMP 0x1F with NOP at 0x1F -> next fetch im_addr=0x00.
5. Store/load: ACC=0xA5, STA 0x07 -> single-cycle dm_wr, dm_addr=0x07, dm_wdata=0xA5; LDA 0x07 then SHL -> ACC=0x4A, C=1; SHR -> ACC=0x25, C=0.
6. Handshake: pulse start during EXEC -> no effect. In HALTED, pulse start -> done=0 next cycle, im_addr=0, im_rd=1, C=0, ACC and io_out retained.

Source files
------------

// File: rtl/scp_mc_core.sv
// scp_mc_core: multi-cycle accumulator processor core.
// Instruction and data memories are external, with synchronous one-cycle reads.
// The core holds PC, IR, ACC, the carry flag and the IO output register.
module scp_mc_core #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            done,
  output logic [AW-1:0]   im_addr,
  output logic            im_rd,
  input  logic [AW+3:0]   im_data,
  output logic [AW-1:0]   dm_addr,
  output logic            dm_rd,
  output logic            dm_wr,
  output logic [DW-1:0]   dm_wdata,
  input  logic [DW-1:0]   dm_rdata,
  input  logic [DW-1:0]   io_in,
  output logic [DW-1:0]   io_out,
  output logic            io_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_STA  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_IN   = 4'h7,
    OP_OUT  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_HALT = 4'hC
  } opcode_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   pc;
  logic [AW+3:0]   ir;
  logic [DW-1:0]   acc;
  logic            c_flag;
  opcode_t         op;
  logic [AW-1:0]   operand;
  logic            zero;
  logic            mem_op;

  assign op      = opcode_t'(ir[AW+3:AW]);
  assign operand = ir[AW-1:0];
  assign zero    = (acc == '0);
  assign mem_op  = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and combinational bus decodes.
  always_comb begin
    state_next = state;
    im_rd      = 1'b0;
    dm_rd      = 1'b0;
    dm_wr      = 1'b0;
    im_addr    = pc;
    dm_addr    = operand;
    dm_wdata   = acc;
    done       = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        im_rd      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        dm_rd = mem_op;
        dm_wr = (op == OP_STA);
        if (mem_op)              state_next = S_MEM;
        else if (op == OP_HALT)  state_next = S_HALTED;
        else                     state_next = S_FETCH;
      end
      S_MEM:    state_next = S_FETCH;
      S_HALTED: begin
        done = 1'b1;
        if (start) state_next = S_FETCH;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: PC, IR, ACC, carry and IO register updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      ir       <= '0;
      acc      <= '0;
      c_flag   <= 1'b0;
      io_out   <= '0;
      io_valid <= 1'b0;
    end else begin
      io_valid <= 1'b0;
      case (state)
        S_IDLE: if (start) pc <= '0;
        S_DECODE: begin
          ir <= im_data;
          pc <= pc + AW'(1);
        end
        S_EXEC: begin
          case (op)
            OP_SHL: {c_flag, acc} <= {acc, 1'b0};
            OP_SHR: begin
              c_flag <= acc[0];
              acc    <= {1'b0, acc[DW-1:1]};
            end
            OP_IN:  acc <= io_in;
            OP_OUT: begin
              io_out   <= acc;
              io_valid <= 1'b1;
            end
            OP_JMP: pc <= operand;
            OP_JZ:  if (zero)   pc <= operand;
            OP_JC:  if (c_flag) pc <= operand;
            default: ;
          endcase
        end
        S_MEM: begin
          case (op)
            OP_LDA: acc <= dm_rdata;
            OP_ADD: {c_flag, acc} <= {1'b0, acc} + {1'b0, dm_rdata};
            OP_SUB: begin
              acc    <= acc - dm_rdata;
              c_flag <= (acc < dm_rdata);
            end
            default: ;
          endcase
        end
        S_HALTED: begin
          if (start) begin
            pc     <= '0;
            c_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scp_mc_core.sv
// Directed testbench for scp_mc_core (DW=8, AW=5) with behavioural memories.
module tb_scp_mc_core;

  localparam int DW = 8;
  localparam int AW = 5;

  localparam logic [3:0] NOP = 4'h0, LDA = 4'h1, STA = 4'h2, ADD = 4'h3,
                         SUB = 4'h4, SHL = 4'h5, SHR = 4'h6, IN  = 4'h7,
                         OUT = 4'h8, JMP = 4'h9, JZ  = 4'hA, JC  = 4'hB,
                         HLT = 4'hC;

  logic            clk;
  logic            reset;
  logic            start;
  logic            done;
  logic [AW-1:0]   im_addr;
  logic            im_rd;
  logic [AW+3:0]   im_data;
  logic [AW-1:0]   dm_addr;
  logic            dm_rd;
  logic            dm_wr;
  logic [DW-1:0]   dm_wdata;
  logic [DW-1:0]   dm_rdata;
  logic [DW-1:0]   io_in;
  logic [DW-1:0]   io_out;
  logic            io_valid;

  logic [AW+3:0]   imem [32];
  logic [DW-1:0]   dmem [32];
  logic [DW-1:0]   wmem [32];
  logic [31:0]     wvalid;

  int tests = 0;
  int fails = 0;
  int n;
  int pulses;
  logic [DW-1:0] outv;

  scp_mc_core #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .im_addr(im_addr), .im_rd(im_rd), .im_data(im_data),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .io_in(io_in), .io_out(io_out), .io_valid(io_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: reads land one cycle later; core writes shadow dmem.
  always @(posedge clk) begin
    im_data  <= imem[im_addr];
    dm_rdata <= wvalid[dm_addr] ? wmem[dm_addr] : dmem[dm_addr];
    if (!reset) wvalid <= '0;
    else if (dm_wr) begin
      wmem[dm_addr]   <= dm_wdata;
      wvalid[dm_addr] <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW+3:0] ins(input logic [3:0] opc, input logic [AW-1:0] a);
    return {opc, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      imem[i] = ins(NOP, 5'd0);
      dmem[i] = '0;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    start = 1'b0;
    ticks(2);
    reset = 1'b1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    io_in = '0;
    clear_mem();
    ticks(2);

    // Reset state
    check("rst_done",   done, 1'b0);
    check("rst_im_rd",  im_rd, 1'b0);
    check("rst_io_out", io_out, 8'h00);
    check("rst_im_addr", im_addr, 5'h00);
    reset = 1'b1;

    // 1. Asynchronous reset during MEM of an ADD
    imem[0] = ins(IN, 5'd0);
    imem[1] = ins(ADD, 5'd3);
    dmem[3] = 8'hE0;
    io_in   = 8'h25;
    start_pulse();
    check("t1_fetch_rd", im_rd, 1'b1);
    ticks(5);
    check("t1_exec_dm_rd", dm_rd, 1'b1);
    check("t1_exec_dm_addr", dm_addr, 5'd3);
    tick();
    check("t1_mem_acc", dut.acc, 8'h25);
    reset = 1'b0;
    #1;
    check("t1_async_strobes", {im_rd, dm_rd, dm_wr, io_valid, done}, 5'b0);
    check("t1_async_acc", dut.acc, 8'h00);
    ticks(2);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t1_idle_strobes", {im_rd, dm_rd, dm_wr, io_valid, done}, 5'b0);
    end
    check("t1_idle_acc", dut.acc, 8'h00);

    // 2. IN, ADD 3, OUT, HALT
    clear_mem();
    imem[0] = ins(IN, 5'd0);
    imem[1] = ins(ADD, 5'd3);
    imem[2] = ins(OUT, 5'd0);
    imem[3] = ins(HLT, 5'd0);
    dmem[3] = 8'hE0;
    io_in   = 8'h25;
    start_pulse();
    n = 0;
    pulses = 0;
    outv = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (io_valid) begin
        pulses++;
        outv = io_out;
      end
      if (done) break;
    end
    check("t2_done_latency", n, 13);
    check("t2_acc", dut.acc, 8'h05);
    check("t2_carry", dut.c_flag, 1'b1);
    check("t2_io_out", io_out, 8'h05);
    check("t2_pulse_val", outv, 8'h05);
    check("t2_pulse_cnt", pulses, 1);

    // 3. SUB borrow, JZ not taken, JC taken
    reset_dut();
    clear_mem();
    imem[0]     = ins(IN, 5'd0);
    imem[1]     = ins(SUB, 5'd4);
    imem[2]     = ins(JZ, 5'h0A);
    imem[3]     = ins(JC, 5'h10);
    imem[5'h10] = ins(HLT, 5'd0);
    dmem[4]     = 8'h05;
    io_in       = 8'h03;
    start_pulse();
    ticks(3 + 4);
    check("t3_sub_acc", dut.acc, 8'hFE);
    check("t3_sub_c", dut.c_flag, 1'b1);
    ticks(3);
    check("t3_jz_not_taken", im_addr, 5'd3);
    check("t3_jz_fetch_rd", im_rd, 1'b1);
    ticks(3);
    check("t3_jc_taken", im_addr, 5'h10);
    ticks(3);
    check("t3_halt_done", done, 1'b1);

    // 4. PC wrap from 0x1F to 0x00
    reset_dut();
    clear_mem();
    imem[0]     = ins(JMP, 5'h1F);
    imem[5'h1F] = ins(NOP, 5'd0);
    start_pulse();
    ticks(3);
    check("t4_jmp_target", im_addr, 5'h1F);
    ticks(3);
    check("t4_wrap", im_addr, 5'h00);

    // 5. STA, LDA, SHL, SHR
    reset_dut();
    clear_mem();
    imem[0] = ins(IN, 5'd0);
    imem[1] = ins(STA, 5'd7);
    imem[2] = ins(IN, 5'd0);
    imem[3] = ins(LDA, 5'd7);
    imem[4] = ins(SHL, 5'd0);
    imem[5] = ins(SHR, 5'd0);
    imem[6] = ins(HLT, 5'd0);
    io_in   = 8'hA5;
    start_pulse();
    ticks(3);
    io_in = 8'h11;
    ticks(2);
    check("t5_sta_wr", dm_wr, 1'b1);
    check("t5_sta_addr", dm_addr, 5'd7);
    check("t5_sta_data", dm_wdata, 8'hA5);
    tick();
    check("t5_sta_single", dm_wr, 1'b0);
    ticks(3);
    check("t5_in2_acc", dut.acc, 8'h11);
    ticks(4);
    check("t5_lda_acc", dut.acc, 8'hA5);
    ticks(3);
    check("t5_shl_acc", dut.acc, 8'h4A);
    check("t5_shl_c", dut.c_flag, 1'b1);
    ticks(3);
    check("t5_shr_acc", dut.acc, 8'h25);
    check("t5_shr_c", dut.c_flag, 1'b0);

    // 6. Start ignored mid-instruction; restart from HALTED
    reset_dut();
    clear_mem();
    imem[0] = ins(IN, 5'd0);
    imem[1] = ins(OUT, 5'd0);
    imem[2] = ins(SHL, 5'd0);
    imem[3] = ins(HLT, 5'd0);
    io_in   = 8'hC3;
    start_pulse();
    ticks(2);
    start_pulse();
    check("t6_start_in_exec", im_addr, 5'd1);
    ticks(3);
    check("t6_out_val", io_out, 8'hC3);
    ticks(3);
    check("t6_shl_c", dut.c_flag, 1'b1);
    ticks(3);
    check("t6_halted", done, 1'b1);
    ticks(2);
    check("t6_halt_hold", done, 1'b1);
    start_pulse();
    check("t6_restart_done", done, 1'b0);
    check("t6_restart_rd", im_rd, 1'b1);
    check("t6_restart_addr", im_addr, 5'd0);
    check("t6_restart_c", dut.c_flag, 1'b0);
    check("t6_keep_acc", dut.acc, 8'h86);
    check("t6_keep_io_out", io_out, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
